// File: rtl/sobel_window_reader_pkg.sv
// Shared types and constants for the Sobel window reader.
// Holds the default pixel width, the packed window width and the tap numbering.
// Tap k of a packed window occupies bits [k*PIX_W +: PIX_W]; TL is tap 8, BR is tap 0.
package sobel_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int WIN_W     = 9 * PIX_W_DEF;

  // Window taps, row-major from top-left (oldest row, oldest column).
  localparam int TAP_TL = 8;
  localparam int TAP_TM = 7;
  localparam int TAP_TR = 6;
  localparam int TAP_ML = 5;
  localparam int TAP_MM = 4;
  localparam int TAP_MR = 3;
  localparam int TAP_BL = 2;
  localparam int TAP_BM = 1;
  localparam int TAP_BR = 0;

  // Pull one pixel out of a packed window.
  function automatic logic [PIX_W_DEF-1:0] win_tap(input logic [WIN_W-1:0] win,
                                                   input int unsigned     k);
    return win[k*PIX_W_DEF +: PIX_W_DEF];
  endfunction

endpackage

// File: rtl/sobel_window_reader_if.sv
// Pixel-in / window-out bundle for the Sobel window reader.
// master drives the raster stream and observes windows; slave is the reader itself.
// No backpressure: pix_valid_i alone qualifies each pixel.
interface sobel_window_reader_if
  import sobel_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = PIX_W_DEF
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic                 pix_valid_i;
  logic [PIX_W-1:0]     pix_i;
  logic [9*PIX_W-1:0]   win_o;
  logic                 win_valid_o;
  logic                 frame_done_o;
  logic [RW-1:0]        row_o;
  logic [CW-1:0]        col_o;

  modport master (
    output pix_valid_i, pix_i,
    input  win_o, win_valid_o, frame_done_o, row_o, col_o
  );

  modport slave (
    input  pix_valid_i, pix_i,
    output win_o, win_valid_o, frame_done_o, row_o, col_o
  );

endinterface

// File: rtl/sobel_window_reader_line_delay.sv
// One-line pixel delay: output is the pixel written exactly DEPTH enables earlier.
// Latency: DEPTH accepted pixels; read is combinational from the current pointer.
// No backpressure; the pointer and memory only move when en is high.
module line_delay
  import sobel_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Read-before-write: the slot under the pointer still holds last line's pixel.
  assign dout_o = mem_q[ptr_q];

  // Next pointer wraps at DEPTH-1 so one line equals one full lap.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  // Pointer register; reset rewinds to slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage is left uncleared; a pixel arriving with reset is dropped.
  always_ff @(posedge clk) begin
    if (en_i && !rst) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/sobel_window_reader.sv
// Builds a 3x3 neighbourhood from a raster stream and flags windows fully inside the image.
// Latency: outputs registered one cycle after each accepted pixel.
// No backpressure; nothing advances on cycles without pix_valid_i.
module sobel_window_reader
  import sobel_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic clk,
  input  logic rst,
  sobel_window_reader_if.slave bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic             acc;
  logic [PIX_W-1:0] a_out;
  logic [PIX_W-1:0] b_out;

  logic [CW-1:0]    col_cnt_q, col_cnt_d;
  logic [RW-1:0]    row_cnt_q, row_cnt_d;
  logic             last_col, last_row, in_window;

  logic [PIX_W-1:0] tap_q [9];
  logic [PIX_W-1:0] tap_d [9];

  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [RW-1:0]    row_out_q;
  logic [CW-1:0]    col_out_q;

  assign acc = bus.pix_valid_i;

  // A holds the previous line; B is fed from A's outgoing pixel, so it lags two lines.
  line_delay #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_delay_a (
    .clk    (clk),
    .rst    (rst),
    .en_i   (acc),
    .din_i  (bus.pix_i),
    .dout_o (a_out)
  );

  line_delay #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_delay_b (
    .clk    (clk),
    .rst    (rst),
    .en_i   (acc),
    .din_i  (a_out),
    .dout_o (b_out)
  );

  // Raster position of the pixel presented this cycle, and where it moves next.
  always_comb begin
    last_col  = (col_cnt_q == CW'(IMG_W - 1));
    last_row  = (row_cnt_q == RW'(IMG_H - 1));
    in_window = (row_cnt_q >= RW'(2)) && (col_cnt_q >= CW'(2));
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (acc) begin
      if (last_col) begin
        col_cnt_d = '0;
        row_cnt_d = last_row ? '0 : row_cnt_q + RW'(1);
      end else begin
        col_cnt_d = col_cnt_q + CW'(1);
      end
    end
    win_valid_d  = acc && in_window;
    frame_done_d = acc && last_col && last_row;
  end

  // Window shift: each row moves left, the new column is {two lines up, one line up, now}.
  always_comb begin
    tap_d[TAP_TL] = tap_q[TAP_TM];
    tap_d[TAP_TM] = tap_q[TAP_TR];
    tap_d[TAP_TR] = b_out;
    tap_d[TAP_ML] = tap_q[TAP_MM];
    tap_d[TAP_MM] = tap_q[TAP_MR];
    tap_d[TAP_MR] = a_out;
    tap_d[TAP_BL] = tap_q[TAP_BM];
    tap_d[TAP_BM] = tap_q[TAP_BR];
    tap_d[TAP_BR] = bus.pix_i;
  end

  // Counters, window register and registered outputs; reset wins over an incoming pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      row_out_q    <= '0;
      col_out_q    <= '0;
      for (int i = 0; i < 9; i++) begin
        tap_q[i] <= '0;
      end
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      if (acc) begin
        tap_q <= tap_d;
      end
      // Report the window centre, one row and one column behind the newest pixel.
      if (win_valid_d) begin
        row_out_q <= row_cnt_q - RW'(1);
        col_out_q <= col_cnt_q - CW'(1);
      end
    end
  end

  assign bus.win_o        = {tap_q[TAP_TL], tap_q[TAP_TM], tap_q[TAP_TR],
                             tap_q[TAP_ML], tap_q[TAP_MM], tap_q[TAP_MR],
                             tap_q[TAP_BL], tap_q[TAP_BM], tap_q[TAP_BR]};
  assign bus.win_valid_o  = win_valid_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.row_o        = row_out_q;
  assign bus.col_o        = col_out_q;

endmodule

// File: tb/tb_sobel_window_reader.sv
// Bench for sobel_window_reader: a 4x4 and a 3x3 instance checked every cycle
// against an image-array model, plus literal window/count expectations.
module tb_sobel_window_reader;
  import sobel_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;

  sobel_window_reader_if #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) bus0 ();
  sobel_window_reader_if #(.IMG_W(3), .IMG_H(3), .PIX_W(8)) bus1 ();

  sobel_window_reader #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0));
  sobel_window_reader #(.IMG_W(3), .IMG_H(3), .PIX_W(8)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1));

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model: frame image + raster position ----------------
  int          mw [2] = '{4, 3};
  int          mh [2] = '{4, 3};
  int          m_r [2];
  int          m_c [2];
  logic [7:0]  img [2][4][4];
  logic        started [2] = '{1'b0, 1'b0};
  logic        e_vld [2];
  logic        e_done [2];
  logic        hold_ok [2];
  logic        chk_rc [2];
  logic [71:0] e_win [2];
  int          e_row [2];
  int          e_col [2];

  task automatic model_step(input int k, input logic rs, input logic pv, input logic [7:0] px);
    if (rs) begin
      started[k] = 1'b1;
      m_r[k] = 0; m_c[k] = 0;
      e_vld[k] = 1'b0; e_done[k] = 1'b0;
      e_win[k] = '0; hold_ok[k] = 1'b1;
      e_row[k] = 0; e_col[k] = 0; chk_rc[k] = 1'b1;
    end else if (pv) begin
      img[k][m_r[k]][m_c[k]] = px;
      e_done[k] = (m_r[k] == mh[k]-1) && (m_c[k] == mw[k]-1);
      if (m_r[k] >= 2 && m_c[k] >= 2) begin
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            e_win[k][(8-(dr*3+dc))*8 +: 8] = img[k][m_r[k]-2+dr][m_c[k]-2+dc];
        e_vld[k] = 1'b1; hold_ok[k] = 1'b1; chk_rc[k] = 1'b1;
        e_row[k] = m_r[k] - 1; e_col[k] = m_c[k] - 1;
      end else begin
        e_vld[k] = 1'b0; hold_ok[k] = 1'b0; chk_rc[k] = 1'b0;
      end
      m_c[k]++;
      if (m_c[k] == mw[k]) begin
        m_c[k] = 0;
        m_r[k]++;
        if (m_r[k] == mh[k]) m_r[k] = 0;
      end
    end else begin
      e_vld[k] = 1'b0; e_done[k] = 1'b0; chk_rc[k] = 1'b0;
    end
  endtask

  task automatic cmp(input string nm, input int k, input logic [71:0] act, input logic [71:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, k, $time, act, req);
    end
  endtask

  task automatic check_dut(input int k, input logic vld, input logic done,
                           input logic [71:0] win, input logic [1:0] row, input logic [1:0] col);
    if (!started[k]) return;
    cmp("win_valid", k, 72'(vld), 72'(e_vld[k]));
    cmp("frame_done", k, 72'(done), 72'(e_done[k]));
    if (hold_ok[k]) cmp("win", k, win, e_win[k]);
    if (chk_rc[k]) begin
      cmp("row", k, 72'(row), 72'(e_row[k]));
      cmp("col", k, 72'(col), 72'(e_col[k]));
    end
  endtask

  // ---------------- monitors for literal checks ----------------
  logic [71:0] q0 [$];
  logic [71:0] q1 [$];
  int          d0 = 0;
  int          d1 = 0;
  int          done_wo_win = 0;
  logic [1:0]  r0_first, c0_first;

  // Single compare process: advance the model on the edge, check outputs 1 time unit later.
  always @(posedge clk) begin
    model_step(0, rst0, bus0.pix_valid_i, bus0.pix_i);
    model_step(1, rst1, bus1.pix_valid_i, bus1.pix_i);
    #1;
    check_dut(0, bus0.win_valid_o, bus0.frame_done_o, bus0.win_o, bus0.row_o, bus0.col_o);
    check_dut(1, bus1.win_valid_o, bus1.frame_done_o, bus1.win_o, bus1.row_o, bus1.col_o);
    if (bus0.win_valid_o) begin
      if (q0.size() == 0) begin r0_first = bus0.row_o; c0_first = bus0.col_o; end
      q0.push_back(bus0.win_o);
    end
    if (bus1.win_valid_o) q1.push_back(bus1.win_o);
    if (bus0.frame_done_o) begin d0++; if (!bus0.win_valid_o) done_wo_win++; end
    if (bus1.frame_done_o) begin d1++; if (!bus1.win_valid_o) done_wo_win++; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int k, input logic v, input logic [7:0] p);
    if (k == 0) begin bus0.pix_valid_i = v; bus0.pix_i = p; end
    else        begin bus1.pix_valid_i = v; bus1.pix_i = p; end
  endtask

  task automatic set_rst(input int k, input logic v);
    if (k == 0) rst0 = v; else rst1 = v;
  endtask

  task automatic push(input int k, input logic [7:0] p, input int gap);
    repeat (gap) begin @(negedge clk); drive(k, 1'b0, 8'($urandom)); end
    @(negedge clk); drive(k, 1'b1, p);
  endtask

  task automatic idle(input int k, input int n);
    repeat (n) begin @(negedge clk); drive(k, 1'b0, 8'($urandom)); end
  endtask

  task automatic clear_mon();
    q0.delete(); q1.delete(); d0 = 0; d1 = 0; done_wo_win = 0;
  endtask

  logic [71:0] lit4 [4] = '{72'h00_01_02_04_05_06_08_09_0A,
                            72'h01_02_03_05_06_07_09_0A_0B,
                            72'h04_05_06_08_09_0A_0C_0D_0E,
                            72'h05_06_07_09_0A_0B_0D_0E_0F};
  logic [71:0] lit100 = 72'h64_65_66_68_69_6A_6C_6D_6E;
  logic [71:0] lit3   = 72'h01_02_03_04_05_06_07_08_09;

  task automatic check_frame4(input string tag);
    cmp({tag, "_nwin"}, 0, 72'(q0.size()), 72'd4);
    for (int i = 0; i < 4; i++)
      if (q0.size() > i) cmp({tag, "_litwin"}, 0, q0[i], lit4[i]);
    cmp({tag, "_ndone"}, 0, 72'(d0), 72'd1);
    cmp({tag, "_done_alone"}, 0, 72'(done_wo_win), 72'd0);
  endtask

  // Watchdog: the sequence below is a few thousand cycles at most.
  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog t=%0t sequence did not complete", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 8'd0); drive(1, 1'b0, 8'd0);
    idle(0, 3);
    @(negedge clk); rst0 = 1'b0; rst1 = 1'b0;
    idle(0, 2);

    // Continuous 0..15 into the 4x4 instance.
    clear_mon();
    for (int i = 0; i < 16; i++) push(0, 8'(i), 0);
    idle(0, 3);
    check_frame4("cont");
    cmp("first_row", 0, 72'(r0_first), 72'd1);
    cmp("first_col", 0, 72'(c0_first), 72'd1);
    if (q0.size() > 0) cmp("centre_tap", 0, 72'(win_tap(q0[0], TAP_MM)), 72'd5);

    // Same stream with 0-3 cycle gaps.
    clear_mon();
    for (int i = 0; i < 16; i++) push(0, 8'(i), $urandom_range(0, 3));
    idle(0, 4);
    check_frame4("gaps");

    // Two frames back-to-back.
    clear_mon();
    for (int i = 0; i < 16; i++) push(0, 8'(i), 0);
    for (int i = 0; i < 16; i++) push(0, 8'(100 + i), 0);
    idle(0, 3);
    cmp("b2b_nwin", 0, 72'(q0.size()), 72'd8);
    if (q0.size() > 4) cmp("b2b_first2", 0, q0[4], lit100);
    cmp("b2b_ndone", 0, 72'(d0), 72'd2);

    // Reset after pixel 9, with a pixel offered in the same cycle as reset.
    for (int i = 0; i < 10; i++) push(0, 8'(i), 0);
    @(negedge clk); set_rst(0, 1'b1); drive(0, 1'b1, 8'd77);
    @(negedge clk); drive(0, 1'b0, 8'd0);
    @(negedge clk); set_rst(0, 1'b0);
    clear_mon();
    for (int i = 0; i < 16; i++) push(0, 8'(i), 0);
    idle(0, 3);
    check_frame4("rst");

    // 3x3 image, stream 1..9.
    clear_mon();
    for (int i = 1; i <= 9; i++) push(1, 8'(i), 0);
    idle(1, 3);
    cmp("w3_nwin", 1, 72'(q1.size()), 72'd1);
    if (q1.size() > 0) cmp("w3_win", 1, q1[0], lit3);
    cmp("w3_ndone", 1, 72'(d1), 72'd1);
    cmp("w3_done_alone", 1, 72'(done_wo_win), 72'd0);

    // Random pixels, random gaps, occasional reset, on both instances.
    for (int n = 0; n < 700; n++) begin
      int k;
      k = (n % 3 == 2) ? 1 : 0;
      if ($urandom_range(0, 149) == 0) begin
        @(negedge clk); set_rst(k, 1'b1); drive(k, 1'($urandom_range(0, 1)), 8'($urandom));
        @(negedge clk); set_rst(k, 1'b0); drive(k, 1'b0, 8'($urandom));
      end
      push(k, 8'($urandom), $urandom_range(0, 2));
      @(negedge clk); drive(k, 1'b0, 8'($urandom));
    end
    idle(0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sobel_window_reader.md
Name: sobel_window_reader

Overview:
Streaming reader on the output side of the line-buffer chain. It accepts a raster pixel stream, keeps two internal one-line delays plus a 3x3 shift register, and presents a complete 3x3 neighbourhood to the Sobel kernel. A window is emitted only when it lies fully inside the image. The block counts rows and columns, gates window validity, and pulses at end of frame.

Parameters:
IMG_W, 128, image width in pixels; legal range is 3 or more.
IMG_H, 128, image height in lines; legal range is 3 or more.
PIX_W, 8, pixel width in bits.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
pix_valid_i  input  1  pix_i carries an accepted pixel this cycle; no backpressure
pix_i  input  PIX_W  pixel, raster order
win_o  output  9*PIX_W  3x3 window; [9*PIX_W-1 -: PIX_W] = top-left (r-2,c-2), row-major, [PIX_W-1:0] = bottom-right (r,c)
win_valid_o  output  1  win_o valid for this cycle
frame_done_o  output  1  one-cycle pulse after the last pixel of a frame
row_o  output  clog2(IMG_H)  row index of the window centre (r-1), valid with win_valid_o
col_o  output  clog2(IMG_W)  column index of the window centre (c-1), valid with win_valid_o

Behaviour:
- Reset (rst=1 at a clk edge): col/row counters=0, win_valid_o=0, frame_done_o=0, win_o=0, row_o=0, col_o=0, window shift register=0. Line-delay memories are not cleared. Delay pointers reset to 0.
- Accept: any cycle with pix_valid_i=1. Gaps of any length are allowed. No state advances on cycles with pix_valid_i=0. On those cycles win_valid_o and frame_done_o are 0 and win_o holds its value.
- Per accepted pixel at (r,c):
  - line delay A outputs the pixel from (r-1,c); line delay B outputs the pixel from (r-2,c).
  - Each line delay reads before it writes at the same address, so its output is the value written exactly IMG_W accepts earlier.
  - The incoming pixel is written into A. A's old value is written into B.
  - Each 3-pixel row of the window register shifts left by one. Rightmost column loads {B_out, A_out, pix_i}.
- Latency: outputs are registered, one cycle after the accept. win_valid_o=1 iff the accepted pixel had r>=2 and c>=2. Then row_o=r-1 and col_o=c-1.
- Windows per frame: (IMG_W-2)*(IMG_H-2). No window is emitted for columns 0/1, which would hold stale data from the previous row. No window is emitted for rows 0/1.
- Counters: col wraps IMG_W-1 -> 0 and increments row. row wraps IMG_H-1 -> 0.
- End of frame: the accept at (IMG_H-1, IMG_W-1) gives frame_done_o=1 on the next cycle, coincident with the final win_valid_o. Counters return to (0,0).
- Back-to-back frames: the next accept is (0,0) of the new frame with no idle cycle required. Its rows 0/1 overwrite the delays before the first window of that frame, so no stale data is exposed.
- Reset mid-frame: all counters and outputs are cleared on the next edge. The first accept after reset is (0,0). No window is produced until new rows 0-1 and columns 0-1 have refilled.
- rst and pix_valid_i both high: reset wins and the pixel is dropped.
- Arithmetic: counters are unsigned. Delay pointer wraps IMG_W-1 -> 0 with no modular overflow beyond the width.

Decomposition:
- Package sobel_pkg:
  - PIX_W default.
  - WIN_W = 9*PIX_W.
  - Localparams for window tap indices (TL..BR = 8..0).
  - Function to extract tap k from win_o.
- Sub-module line_delay (DEPTH=IMG_W, PIX_W):
  - single wrapping pointer
  - read-before-write
  - en input
  - the block instantiates it twice.

Test Plan:
- IMG_W=4, IMG_H=4, continuous pix_i=0..15 -> first win_valid_o 1 cycle after pixel 10. win_o = {0,1,2,4,5,6,8,9,10}, row_o=1, col_o=1. Exactly 4 windows. Last window = {5,6,7,9,10,11,13,14,15} with frame_done_o=1 in the same cycle.
- Same stream with random 0-3 cycle gaps on pix_valid_i -> identical window sequence. win_valid_o never asserted in gap cycles. win_o stable across gaps.
- Two frames back-to-back (values 0..15 then 100..115) -> second frame's first window is {100,101,102,104,105,106,108,109,110}. No window is emitted for pixels 100..109 except as required. frame_done_o pulses twice.
- Reset asserted after pixel 9 of frame 1, then stream 0..15 -> no output during reset. Output afterwards matches the clean single-frame case exactly. frame_done_o pulses once.
- rst and pix_valid_i high in the same cycle -> pixel ignored, counters 0, win_valid_o=0 next cycle.
- IMG_W=IMG_H=3, stream 1..9 -> a single window {1..9} with frame_done_o in the same cycle.
